// File: rtl/dbus_ctrl_if.sv
// Request/response and bus handshake bundle for dbus_ctrl.
// slave = the controller; master = the pipeline plus memory side.
interface dbus_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] daddr;
  logic [1:0]  dsize;
  logic        dreq;
  logic        dwrite;
  logic        dready_n;
  logic        dbusy;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  dready_n, dbusy,
    output stall, rsp_valid, rsp_rdata, rsp_err,
    output daddr, dsize, dreq, dwrite
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output dready_n, dbusy,
    input  stall, rsp_valid, rsp_rdata, rsp_err,
    input  daddr, dsize, dreq, dwrite
  );
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus controller for the MEM stage: one load/store at a time, lane alignment, stall.
// Optional bus-wait timeout enabled by defining DBUS_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module dbus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  dbus_ctrl_if.slave  bus,
  inout  wire  [31:0] ddata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nx;
  logic [1:0]  size_q;
  logic        wr_q, uns_q, err_q, err_nx;
  logic        misal, bus_done, tmo;
  logic [31:0] st_lanes, ld_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("TIMEOUT_CYCLES out of range");
  end

  assign misal = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign bus_done = !bus.dready_n && !bus.dbusy;

`ifdef DBUS_TIMEOUT_EN
  logic [15:0] cnt_q;
  // Held at zero outside REQ, so it is clear on every entry to REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt_q <= '0;
    else if (state != REQ) cnt_q <= '0;
    else                   cnt_q <= cnt_q + 16'd1;
  end
  assign tmo = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    st_lanes = wdata_q;
    case (size_q)
      2'b00:   st_lanes = {4{wdata_q[7:0]}};
      2'b01:   st_lanes = {2{wdata_q[15:0]}};
      default: st_lanes = wdata_q;
    endcase
  end

  always_comb begin
    ld_b = ddata[7:0];
    case (addr_q[1:0])
      2'd0:    ld_b = ddata[7:0];
      2'd1:    ld_b = ddata[15:8];
      2'd2:    ld_b = ddata[23:16];
      default: ld_b = ddata[31:24];
    endcase
    ld_h = addr_q[1] ? ddata[31:16] : ddata[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = ddata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (misal) begin
          state_nx = DONE;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end else begin
          state_nx = REQ;
          err_nx   = 1'b0;
        end
      end
      REQ: if (bus_done) begin
        state_nx = DONE;
        err_nx   = 1'b0;
        rdata_nx = wr_q ? 32'b0 : ld_ext;
      end else if (tmo) begin
        state_nx = DONE;
        err_nx   = 1'b1;
        rdata_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      if (state == IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        wr_q    <= bus.req_write;
        uns_q   <= bus.req_unsigned;
      end
    end
  end

  assign bus.dreq      = (state == REQ);
  assign bus.dwrite    = (state == REQ) && wr_q;
  assign bus.daddr     = addr_q;
  assign bus.dsize     = size_q;
  assign bus.stall     = bus.req_valid && (state != DONE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_err   = (state == DONE) && err_q;
  assign bus.rsp_rdata = rdata_q;
  assign ddata         = ((state == REQ) && wr_q) ? st_lanes : 32'bz;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: per-cycle expected timeline built from the access rules,
// checked at every negedge, plus literal checks on captured results.
module tb_dbus_ctrl;
`ifdef DBUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_drive;
  logic [31:0] tb_bus;
  wire  [31:0] ddata;

  dbus_ctrl_if bus_if();

  assign ddata = tb_drive ? tb_bus : 32'bz;

  dbus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave),
    .ddata(ddata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, dreq, dwrite, rv, err;
    logic [1:0]  dsize;
    logic [31:0] daddr, ddata, rdata;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          dreq_cycles = 0;
  int          rsp_count = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] last_wbus = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (sz == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] ext(input logic [1:0] sz, input logic uns,
                                      input logic [31:0] a, input logic [31:0] bv);
    logic [31:0] s;
    s = bv >> (8 * a[1:0]);
    if (sz == 2'b00) return uns ? (s & 32'hFF) : ((s & 32'h80) != 0 ? (s | 32'hFFFFFF00) : (s & 32'hFF));
    if (sz == 2'b01) return uns ? (s & 32'hFFFF) : ((s & 32'h8000) != 0 ? (s | 32'hFFFF0000) : (s & 32'hFFFF));
    return bv;
  endfunction

  always @(negedge clk) begin
    if (bus_if.dreq === 1'b1) dreq_cycles++;
    if (bus_if.dreq === 1'b1 && bus_if.dwrite === 1'b1) last_wbus = ddata;
    if (bus_if.rsp_valid === 1'b1) begin
      rsp_count++;
      last_rdata = bus_if.rsp_rdata;
      last_err   = bus_if.rsp_err;
    end
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", 32'(bus_if.stall), 32'(e.stall));
      chk("dreq", 32'(bus_if.dreq), 32'(e.dreq));
      chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(e.rv));
      if (e.dreq) begin
        chk("dwrite", 32'(bus_if.dwrite), 32'(e.dwrite));
        chk("dsize", 32'(bus_if.dsize), 32'(e.dsize));
        chk("daddr", bus_if.daddr, e.daddr);
        if (e.dwrite) chk("ddata", ddata, e.ddata);
      end
      if (e.rv) begin
        chk("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
        chk("rsp_rdata", bus_if.rsp_rdata, e.rdata);
      end
    end
  end

  // nreq = REQ cycle on which the bus completes (0 = never); busy = stall via dbusy instead of dready_n.
  task automatic run(input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bv,
                     input int nreq, input bit busy);
    exp_t e;
    bit   mis, tmo, inreq;
    int   nq, n;
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    tmo = 1'b0;
    nq  = nreq;
`ifdef DBUS_TIMEOUT_EN
    if (nreq == 0 || nreq > TO) begin tmo = 1'b1; nq = TO; end
`endif
    if (mis) begin nq = 0; tmo = 1'b0; end
    e = '{default: '0}; e.stall = 1'b1; q.push_back(e);
    for (int j = 1; j <= nq; j++) begin
      e = '{default: '0};
      e.stall = 1'b1; e.dreq = 1'b1; e.dwrite = wr; e.dsize = sz; e.daddr = a;
      e.ddata = lanes(sz, wd);
      q.push_back(e);
    end
    e = '{default: '0}; e.rv = 1'b1; e.err = mis || tmo;
    e.rdata = (mis || tmo || wr) ? 32'h0 : ext(sz, uns, a, bv);
    q.push_back(e);
    e = '{default: '0}; q.push_back(e);
    n = nq + 3;
    tb_drive = !wr;
    tb_bus   = bv;
    for (int j = 0; j < n; j++) begin
      bus_if.req_valid    = (j < n - 1);
      bus_if.req_write    = wr;
      bus_if.req_size     = sz;
      bus_if.req_unsigned = uns;
      bus_if.req_addr     = a;
      bus_if.req_wdata    = wd;
      inreq = !mis && j >= 1 && j <= nq;
      if (inreq && !tmo && j == nq) begin
        bus_if.dready_n = 1'b0; bus_if.dbusy = 1'b0;
      end else if (inreq && busy) begin
        bus_if.dready_n = 1'b0; bus_if.dbusy = 1'b1;
      end else begin
        bus_if.dready_n = 1'b1; bus_if.dbusy = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int d0, r0;
    rst = 1'b0;
    tb_drive = 1'b0; tb_bus = '0;
    bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_size = 2'b00;
    bus_if.req_unsigned = 1'b0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
    bus_if.dready_n = 1'b1; bus_if.dbusy = 1'b0;
    @(negedge clk);
    chk("rst_dreq", 32'(bus_if.dreq), 32'h0);
    chk("rst_dwrite", 32'(bus_if.dwrite), 32'h0);
    chk("rst_daddr", bus_if.daddr, 32'h0);
    chk("rst_dsize", 32'(bus_if.dsize), 32'h0);
    chk("rst_stall", 32'(bus_if.stall), 32'h0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    d0 = dreq_cycles;
    run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_dreq_cycles", 32'(dreq_cycles - d0), 32'd1);
    run(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    run(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
    chk("lbu_rdata", last_rdata, 32'h00000080);
    run(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1, 1'b0);
    chk("sh_bus", last_wbus, 32'hABCDABCD);

    d0 = dreq_cycles; r0 = rsp_count;
    run(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 4, 1'b1);
    chk("busy_dreq_cycles", 32'(dreq_cycles - d0), 32'd4);
    chk("busy_rsp_count", 32'(rsp_count - r0), 32'd1);

    d0 = dreq_cycles;
    run(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1, 1'b0);
    chk("mis_err", 32'(last_err), 32'h1);
    chk("mis_dreq_cycles", 32'(dreq_cycles - d0), 32'd0);

    run(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'h80010000, 1, 1'b0);
    chk("lh_rdata", last_rdata, 32'hFFFF8001);
    run(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h80010000, 2, 1'b0);
    chk("lhu_rdata", last_rdata, 32'h00008001);
    run(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000055, 32'h0, 3, 1'b0);
    chk("sb_bus", last_wbus, 32'h55555555);
    run(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 1, 1'b0);
    run(1'b1, 2'b01, 1'b0, 32'h201, 32'h1111, 32'h0, 1, 1'b0);
    run(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'h89ABCDEF, 1, 1'b0);
    run(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h00007F00, 2, 1'b1);
    chk("lb_pos_rdata", last_rdata, 32'h0000007F);

`ifdef DBUS_TIMEOUT_EN
    d0 = dreq_cycles;
    run(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h12345678, 0, 1'b0);
    chk("tmo_err", 32'(last_err), 32'h1);
    chk("tmo_dreq_cycles", 32'(dreq_cycles - d0), 32'd4);
    run(1'b0, 2'b10, 1'b0, 32'h604, 32'h0, 32'h12345678, 4, 1'b0);
    chk("tmo_edge_rdata", last_rdata, 32'h12345678);
`endif

    // Abort mid-REQ: reset must drop dreq combinationally and suppress the response.
    r0 = rsp_count;
    tb_drive = 1'b1; tb_bus = 32'h0;
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_size = 2'b10;
    bus_if.req_addr = 32'h500; bus_if.dready_n = 1'b1; bus_if.dbusy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_dreq", 32'(bus_if.dreq), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("abort_dreq", 32'(bus_if.dreq), 32'h0);
    chk("abort_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rsp_count", 32'(rsp_count - r0), 32'd0);
    run(1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 32'hA5A5A5A5, 1, 1'b0);
    chk("recover_rdata", last_rdata, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbus_ctrl.md
# dbus_ctrl

Data-bus controller between the memory-access stage of the 5-stage RV32I core and the external data bus (daddr/ddata/dsize/dreq/dwrite/dready_n/dbusy). It accepts one load or store request at a time from the memory-access stage and runs the bus handshake. It aligns store data onto byte lanes and extracts and sign- or zero-extends load data. It also drives the stall that freezes the pipeline until the access completes.

## Interface
- TIMEOUT_CYCLES, 255: bus-wait limit in cycles; legal range 1..65535; used only with DBUS_TIMEOUT_EN.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  memory-access stage has a load/store; held stable until rsp_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 is treated as word.
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- stall  out  1  freeze pipeline: req_valid && state != DONE.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data, valid with rsp_valid; 0 for stores and errors.
- rsp_err  out  1  with rsp_valid: misaligned access or timeout.
- daddr  out  32  bus address (latched req_addr).
- dsize  out  2  bus size, same encoding as req_size.
- dreq  out  1  bus request.
- dwrite  out  1  1 = write cycle.
- ddata  inout  32  driven only while dreq && dwrite, else high-Z.
- dready_n  in  1  active-low completion from memory.
- dbusy  in  1  memory busy; completion is ignored while high.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - If req_valid, latch addr, size, write, unsigned and wdata.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. A misaligned request goes to DONE with rsp_err=1 and never asserts dreq.
  - Otherwise go to REQ.
- REQ:
  - Drive dreq=1, daddr, dsize and dwrite from the latched values.
  - Completion is dready_n==0 && dbusy==0. On completion, capture ddata for loads and go to DONE.
  - Otherwise stay in REQ; there is no bound on the wait without the macro.
- DONE: rsp_valid=1 for exactly one cycle, then return to IDLE unconditionally.
- Lane mapping is little-endian; the byte at addr[1:0]=k occupies ddata[8k+7:8k].
  - Store byte: wdata[7:0] replicated to all four lanes.
  - Store half: wdata[15:0] replicated to both halves.
  - Store word: wdata as-is.
- Load extraction: select the lane(s) using latched addr[1:0], then sign-extend from bit 7 (byte) or bit 15 (half), or zero-extend when unsigned. Word loads pass through.
- rsp_rdata is registered at the REQ→DONE transition.

## Timing
- Reset values: dreq=0, dwrite=0, daddr=0, dsize=00, ddata=Z, stall=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Best-case latency: req_valid seen at edge N; REQ during cycle N..N+1; dready_n=0 sampled at edge N+1; rsp_valid high during cycle N+1..N+2. Stall is high for 2 cycles.
- Misaligned request: rsp_valid/rsp_err appear one cycle after the request is seen; stall is high for 1 cycle.
- dbusy=1 coinciding with dready_n=0 is not completion; the block stays in REQ.
- In the DONE cycle stall=0, so the pipeline advances. A new req_valid is first sampled in the following IDLE cycle, which leaves one idle bus cycle between accesses.
- Reset asserted mid-access: the block asynchronously goes to IDLE, dreq drops and ddata releases immediately, and no rsp_valid is produced for the aborted access.
- req_valid dropping during REQ is illegal (nop/flush is never applied to the MEM stage while stall is high). The bus cycle still completes.

## Configuration
- DBUS_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle.
  - When the count reaches TIMEOUT_CYCLES without completion, go to DONE with rsp_err=1 and rsp_rdata=0, and deassert dreq.
- DBUS_TIMEOUT_EN undefined: no counter exists, and REQ waits indefinitely.

## Test plan
- Load word: addr=0x100, ddata=0xDEADBEEF, dready_n=0 in the first REQ cycle -> one REQ cycle with dreq=1, dwrite=0, dsize=10; rsp_rdata=0xDEADBEEF; stall high 2 cycles.
- Byte loads at addr=0x103 with ddata=0x80FF0000:
  - LB -> rsp_rdata=0xFFFFFF80.
  - LBU -> rsp_rdata=0x00000080.
- Store half: addr=0x202, wdata=0x1234ABCD -> dsize=01, dwrite=1, ddata=0xABCDABCD while dreq; Z afterwards.
- dbusy=1 for 3 cycles with dready_n=0 held -> dreq stays high 4 cycles; a single rsp_valid after dbusy falls.
- Misaligned word load at addr=0x102 -> dreq never asserts; rsp_valid=1 and rsp_err=1 one cycle later.
- Timeout and reset:
  - With DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, dready_n held 1 -> rsp_err=1 after 4 REQ cycles.
  - rst=0 mid-REQ -> dreq=0 with no clock edge required.
